// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I MEM stage: byte-serial loads/stores over the shared memory port
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [5:0]  memop_type_i,
    input  logic [31:0] mem_w_data_i,
    output logic [4:0]  mem_wd_o,
    output logic        mem_wreg_o,
    output logic [31:0] mem_wdata_o,
    output logic [5:0]  memop_type_o,
    output logic [31:0] mem_w_data_o,
    output logic        stall_req_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_a_o,
    output logic [7:0]  mem_dout_o,
    input  logic [7:0]  mem_din_i,
    input  logic        mem_gnt_i
);
    localparam logic [5:0] OP_NONE = 6'h00;
    localparam logic [5:0] OP_LB   = 6'h01;
    localparam logic [5:0] OP_LH   = 6'h02;
    localparam logic [5:0] OP_LW   = 6'h03;
    localparam logic [5:0] OP_LBU  = 6'h04;
    localparam logic [5:0] OP_LHU  = 6'h05;
    localparam logic [5:0] OP_SB   = 6'h06;
    localparam logic [5:0] OP_SH   = 6'h07;
    localparam logic [5:0] OP_SW   = 6'h08;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_LASTRD, S_DONE} state_t;

    state_t      state_q;
    logic [1:0]  idx_q;
    logic [1:0]  rd_idx_q;
    logic        rd_pend_q;
    logic [31:0] buf_q;

    logic        is_load;
    logic        is_store;
    logic [1:0]  last_idx;
    logic        rd_grant;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        last_idx = 2'd3;
        case (memop_type_i)
            OP_NONE:        is_load = 1'b0;
            OP_LB, OP_LBU:  begin is_load  = 1'b1; last_idx = 2'd0; end
            OP_LH, OP_LHU:  begin is_load  = 1'b1; last_idx = 2'd1; end
            OP_LW:          is_load  = 1'b1;
            OP_SB:          begin is_store = 1'b1; last_idx = 2'd0; end
            OP_SH:          begin is_store = 1'b1; last_idx = 2'd1; end
            OP_SW:          is_store = 1'b1;
            default:        is_load = 1'b0;
        endcase
    end

    assign rd_grant = (state_q == S_BUSY) && mem_gnt_i && is_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            rd_idx_q  <= 2'd0;
            rd_pend_q <= 1'b0;
            buf_q     <= 32'd0;
        end else begin
            // Read data trails its grant by one cycle, so capture uses the index saved at grant time.
            if (rd_pend_q)
                buf_q[{rd_idx_q, 3'b000} +: 8] <= mem_din_i;
            rd_pend_q <= rd_grant;
            case (state_q)
                S_IDLE: begin
                    idx_q <= 2'd0;
                    if (is_load || is_store)
                        state_q <= S_BUSY;
                end
                S_BUSY: begin
                    if (mem_gnt_i) begin
                        idx_q <= idx_q + 2'd1;
                        if (is_load)
                            rd_idx_q <= idx_q;
                        if (idx_q == last_idx)
                            state_q <= is_load ? S_LASTRD : S_DONE;
                    end
                end
                S_LASTRD: state_q <= S_DONE;
                S_DONE:   state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_wd_o     = 5'd0;
        mem_wreg_o   = 1'b0;
        mem_wdata_o  = 32'd0;
        memop_type_o = 6'd0;
        mem_w_data_o = 32'd0;
        stall_req_o  = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_a_o      = 32'd0;
        mem_dout_o   = 8'd0;
        if (!rst) begin
            mem_wd_o     = wd_i;
            mem_wreg_o   = wreg_i;
            mem_wdata_o  = wdata_i;
            memop_type_o = memop_type_i;
            mem_w_data_o = mem_w_data_i;
            case (state_q)
                S_IDLE: begin
                    if (is_load || is_store) begin
                        stall_req_o = 1'b1;
                        mem_wreg_o  = 1'b0;
                    end
                end
                S_BUSY: begin
                    stall_req_o = 1'b1;
                    mem_wreg_o  = 1'b0;
                    mem_req_o   = 1'b1;
                    mem_we_o    = is_store;
                    mem_a_o     = wdata_i + {30'd0, idx_q};
                    mem_dout_o  = mem_w_data_i[{idx_q, 3'b000} +: 8];
                end
                S_LASTRD: begin
                    stall_req_o = 1'b1;
                    mem_wreg_o  = 1'b0;
                end
                S_DONE: begin
                    case (memop_type_i)
                        OP_LB:   mem_wdata_o = {{24{buf_q[7]}}, buf_q[7:0]};
                        OP_LBU:  mem_wdata_o = {24'd0, buf_q[7:0]};
                        OP_LH:   mem_wdata_o = {{16{buf_q[15]}}, buf_q[15:0]};
                        OP_LHU:  mem_wdata_o = {16'd0, buf_q[15:0]};
                        OP_LW:   mem_wdata_o = buf_q;
                        default: mem_wdata_o = wdata_i;
                    endcase
                end
                default: stall_req_o = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a byte-memory model
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [5:0]  memop_type_i;
    logic [31:0] mem_w_data_i;
    logic [4:0]  mem_wd_o;
    logic        mem_wreg_o;
    logic [31:0] mem_wdata_o;
    logic [5:0]  memop_type_o;
    logic [31:0] mem_w_data_o;
    logic        stall_req_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic [7:0]  mem_din_i;
    logic        mem_gnt_i;

    int errors = 0;
    int checks = 0;

    mem_stage dut (
        .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .memop_type_i(memop_type_i), .mem_w_data_i(mem_w_data_i),
        .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
        .memop_type_o(memop_type_o), .mem_w_data_o(mem_w_data_o),
        .stall_req_o(stall_req_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_din_i(mem_din_i),
        .mem_gnt_i(mem_gnt_i)
    );

    always #5 clk = ~clk;

    // Byte-addressed memory; unwritten locations read as zero.
    logic [7:0] mem [logic [31:0]];
    logic       s_acc;
    logic       s_we;
    logic [31:0] s_a;
    logic [7:0] s_dout;

    function automatic logic [7:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    always @(negedge clk) begin
        s_acc  = mem_req_o & mem_gnt_i;
        s_we   = mem_we_o;
        s_a    = mem_a_o;
        s_dout = mem_dout_o;
    end

    always @(posedge clk) begin
        if (s_acc && s_we)
            mem[s_a] = s_dout;
        if (s_acc && !s_we)
            mem_din_i <= rd(s_a);
        else
            mem_din_i <= 8'($urandom);
        s_acc = 1'b0;
    end

    function automatic int op_bytes(input logic [5:0] op);
        case (op)
            6'h01, 6'h04, 6'h06: return 1;
            6'h02, 6'h05, 6'h07: return 2;
            default:             return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_value(input logic [5:0] op, input logic [31:0] a);
        logic [31:0] w;
        w = {rd(a + 32'd3), rd(a + 32'd2), rd(a + 32'd1), rd(a)};
        case (op)
            6'h01:   return 32'($signed(w[7:0]));
            6'h04:   return {24'd0, w[7:0]};
            6'h02:   return 32'($signed(w[15:0]));
            6'h05:   return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic do_mem(input string name, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [63:0] gpat);
        int n, g, busy_end, exp_cycles, cyc, acc, req_cycles;
        bit ld, done, wreg_bad;
        logic [31:0] exp_res;
        logic [4:0] wd;
        n  = op_bytes(op);
        ld = (op >= 6'h01) && (op <= 6'h05);
        // Busy cycles start at cycle 1 and last until the n-th granted cycle.
        g = 0;
        busy_end = 1;
        while (g < n) begin
            if (gpat[busy_end]) g++;
            busy_end++;
        end
        exp_cycles = busy_end + (ld ? 1 : 0) + 1;
        exp_res = ld ? load_value(op, addr) : addr;
        wd = 5'($urandom);
        wd_i = wd; wreg_i = 1'b1; wdata_i = addr; memop_type_i = op;
        mem_w_data_i = sdata; mem_gnt_i = gpat[0];
        cyc = 0; acc = 0; req_cycles = 0; done = 0; wreg_bad = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            if (mem_req_o) begin
                req_cycles++;
                if (mem_gnt_i) begin
                    checks++;
                    if (acc >= n || mem_a_o !== addr + 32'(acc) || mem_we_o !== !ld ||
                        (!ld && mem_dout_o !== 8'(sdata >> (8 * acc)))) begin
                        errors++;
                        $display("FAIL %s access%0d: a=%h we=%b dout=%h, want a=%h we=%b dout=%h",
                                 name, acc, mem_a_o, mem_we_o, mem_dout_o, addr + 32'(acc), !ld,
                                 8'(sdata >> (8 * acc)));
                    end
                    acc++;
                end
            end
            if (stall_req_o) begin
                if (mem_wreg_o !== 1'b0) wreg_bad = 1;
            end else begin
                done = 1;
                checks++;
                if (cyc + 1 != exp_cycles || mem_wdata_o !== exp_res || mem_wreg_o !== 1'b1 ||
                    mem_wd_o !== wd || memop_type_o !== op || mem_w_data_o !== sdata) begin
                    errors++;
                    $display("FAIL %s done: cycles=%0d wdata=%h wreg=%b wd=%0d op=%h, want cycles=%0d wdata=%h wreg=1 wd=%0d op=%h",
                             name, cyc + 1, mem_wdata_o, mem_wreg_o, mem_wd_o, memop_type_o,
                             exp_cycles, exp_res, wd, op);
                end
            end
            if (!done) begin
                @(posedge clk); #1;
                cyc++;
                mem_gnt_i = gpat[cyc];
            end
        end
        checks++;
        if (!done || acc != n || req_cycles != busy_end - 1 || wreg_bad) begin
            errors++;
            $display("FAIL %s bus: done=%b grants=%0d req_cycles=%0d wreg_in_stall=%b, want done=1 grants=%0d req_cycles=%0d wreg_in_stall=0",
                     name, done, acc, req_cycles, wreg_bad, n, busy_end - 1);
        end
        @(posedge clk); #1;
        memop_type_i = 6'h00; mem_gnt_i = 1'b0;
        if (!ld) begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (rd(addr + 32'(i)) !== 8'(sdata >> (8 * i))) begin
                    errors++;
                    $display("FAIL %s mem[%h]: got %h, want %h", name, addr + 32'(i),
                             rd(addr + 32'(i)), 8'(sdata >> (8 * i)));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hDEADBEEF;
        memop_type_i = 6'h03; mem_w_data_i = 32'h12345678; mem_gnt_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({mem_wd_o, mem_wreg_o, mem_wdata_o, memop_type_o, mem_w_data_o, stall_req_o,
             mem_req_o, mem_we_o, mem_a_o, mem_dout_o} !== '0) begin
            errors++;
            $display("FAIL reset outputs: req=%b stall=%b wdata=%h, want all zero",
                     mem_req_o, stall_req_o, mem_wdata_o);
        end
        @(posedge clk); #1;
        rst = 1'b0; memop_type_i = 6'h00; mem_gnt_i = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [5:0] ops [3] = '{6'h00, 6'h2A, 6'h09};
        for (int i = 0; i < 6; i++) begin
            wd_i = 5'($urandom); wreg_i = 1'($urandom);
            wdata_i = (i == 0) ? 32'h1234 : $urandom;
            if (i == 0) wreg_i = 1'b1;
            memop_type_i = ops[i % 3]; mem_w_data_i = $urandom; mem_gnt_i = 1'($urandom);
            @(negedge clk);
            checks++;
            if (mem_wd_o !== wd_i || mem_wreg_o !== wreg_i || mem_wdata_o !== wdata_i ||
                memop_type_o !== memop_type_i || mem_w_data_o !== mem_w_data_i ||
                stall_req_o !== 1'b0 || mem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL passthrough%0d: wdata=%h wreg=%b stall=%b req=%b, want wdata=%h wreg=%b stall=0 req=0",
                         i, mem_wdata_o, mem_wreg_o, stall_req_o, mem_req_o, wdata_i, wreg_i);
            end
            @(posedge clk); #1;
        end
        memop_type_i = 6'h00; mem_gnt_i = 1'b0;
    endtask

    task automatic test_loads();
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'hF2;
        mem[32'h200] = 8'h80; mem[32'h201] = 8'hFF;
        do_mem("lw_basic", 6'h03, 32'h100, 32'h0, '1);
        do_mem("lb", 6'h01, 32'h200, 32'h0, '1);
        do_mem("lbu", 6'h04, 32'h200, 32'h0, '1);
        do_mem("lh", 6'h02, 32'h200, 32'h0, '1);
        do_mem("lhu", 6'h05, 32'h200, 32'h0, '1);
        do_mem("lw_toggle", 6'h03, 32'h100, 32'h0, 64'hFFFF_FFFF_FFFF_FFEB);
    endtask

    task automatic test_store_wrap();
        do_mem("sh_wrap", 6'h07, 32'hFFFF_FFFF, 32'hAABBCCDD, 64'hFFFF_FFFF_FFFF_FFF9);
        do_mem("sb", 6'h06, 32'h400, 32'h0000_005A, '1);
        do_mem("sw", 6'h08, 32'h404, 32'h8765_4321, '1);
    endtask

    task automatic test_reset_mid_access();
        for (int i = 0; i < 4; i++) mem[32'h300 + 32'(i)] = 8'h11;
        wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h300; memop_type_i = 6'h08;
        mem_w_data_i = 32'hCAFEBABE; mem_gnt_i = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_wd_o, mem_wreg_o, mem_wdata_o, memop_type_o, mem_w_data_o, stall_req_o,
             mem_req_o, mem_we_o, mem_a_o, mem_dout_o} !== '0) begin
            errors++;
            $display("FAIL rst_mid outputs: req=%b stall=%b a=%h, want all zero",
                     mem_req_o, stall_req_o, mem_a_o);
        end
        @(posedge clk); #1;
        rst = 1'b0; memop_type_i = 6'h00;
        @(negedge clk);
        checks++;
        if (stall_req_o !== 1'b0 || mem_req_o !== 1'b0 || rd(32'h300) !== 8'hBE ||
            rd(32'h301) !== 8'hBA || rd(32'h302) !== 8'h11) begin
            errors++;
            $display("FAIL rst_mid after: stall=%b req=%b mem=%h %h %h, want stall=0 req=0 mem=be ba 11",
                     stall_req_o, mem_req_o, rd(32'h300), rd(32'h301), rd(32'h302));
        end
        @(posedge clk); #1;
        mem[32'h500] = 8'hC3;
        do_mem("lb_after_rst", 6'h01, 32'h500, 32'h0, '1);
    endtask

    task automatic test_random();
        logic [5:0]  op;
        logic [31:0] addr;
        for (int i = 0; i < 25; i++) begin
            op = 6'($urandom_range(1, 8));
            addr = (i % 4 == 0) ? 32'hFFFF_FFFE : $urandom;
            for (int b = 0; b < 4; b++) mem[addr + 32'(b)] = 8'($urandom);
            do_mem("random", op, addr, $urandom, {32'hFFFF_FFFF, 32'($urandom)});
        end
    endtask

    initial begin
        mem_gnt_i = 1'b0;
        test_reset();
        test_passthrough();
        test_loads();
        test_store_wrap();
        test_reset_mid_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
